// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter for the integer pipeline. It merges the single-cycle ALU
// result path and the variable-latency load result path onto the one
// register-file write port. Load results are held in a small circular FIFO.
// The ALU normally has priority. A non-empty FIFO that has lost to the ALU
// STARVE_MAX times in a row is forced through on the next cycle.
//
// Optional feature (macro WB_SCOREBOARD_EN):
//   When defined, a 32-entry pending-load scoreboard is kept so decode can
//   detect load-use hazards through rs1_busy/rs2_busy. When undefined,
//   ld_issue/ld_issue_rd are ignored and both busy outputs read 0.
//
// Parameters:
//   DEPTH       load-result FIFO entries (power of two, >= 2)
//   STARVE_MAX  ALU wins tolerated against a non-empty FIFO (1..15)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_valid/alu_ready            ALU handshake (ready is combinational)
//   alu_rd, alu_data               ALU destination and result
//   mem_valid/mem_ready            load handshake (ready = FIFO not full)
//   mem_rd, mem_data               load destination and result
//   ld_issue, ld_issue_rd          load issue notification for the scoreboard
//   rs1, rs2 / rs1_busy, rs2_busy  decode source registers and hazard flags
//   RegWrite, rd, rd_write_data    registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] rd_write_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW:0]    rd_ptr_reg, rd_ptr_next;
  logic [4:0]     fifo_rd_mem   [DEPTH];
  logic [31:0]    fifo_data_mem [DEPTH];
  logic [CW-1:0]  starve_cnt_reg, starve_cnt_next;

  logic           reg_write_reg, reg_write_next;
  logic [4:0]     rd_reg, rd_next;
  logic [31:0]    data_reg, data_next;

  logic           fifo_empty, fifo_full;
  logic           force_pop, pop, push;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // ---------------------------------------------------------------------------
  // Arbitration and next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    force_pop       = !fifo_empty && (starve_cnt_reg == STARVE_LIM);
    alu_ready       = !force_pop;
    // Occupancy uses start-of-cycle state: a full FIFO refuses even while popping.
    mem_ready       = !fifo_full;
    push            = mem_valid && !fifo_full && (mem_rd != 5'd0);
    pop             = force_pop || (!alu_valid && !fifo_empty);

    reg_write_next  = 1'b0;
    rd_next         = rd_reg;
    data_next       = data_reg;
    starve_cnt_next = '0;

    if (force_pop) begin
      reg_write_next = 1'b1;
      rd_next        = fifo_rd_mem[rd_ptr_reg[AW-1:0]];
      data_next      = fifo_data_mem[rd_ptr_reg[AW-1:0]];
    end else if (alu_valid) begin
      // An ALU result to x0 is consumed but never written.
      if (alu_rd != 5'd0) begin
        reg_write_next = 1'b1;
        rd_next        = alu_rd;
        data_next      = alu_data;
      end
      if (!fifo_empty) begin
        starve_cnt_next = starve_cnt_reg + CW'(1);
      end
    end else if (!fifo_empty) begin
      reg_write_next = 1'b1;
      rd_next        = fifo_rd_mem[rd_ptr_reg[AW-1:0]];
      data_next      = fifo_data_mem[rd_ptr_reg[AW-1:0]];
    end

    wr_ptr_next = push ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
    rd_ptr_next = pop  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      starve_cnt_reg <= '0;
      reg_write_reg  <= 1'b0;
      rd_reg         <= '0;
      data_reg       <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      starve_cnt_reg <= starve_cnt_next;
      reg_write_reg  <= reg_write_next;
      rd_reg         <= rd_next;
      data_reg       <= data_next;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg[AW-1:0]]   <= mem_rd;
      fifo_data_mem[wr_ptr_reg[AW-1:0]] <= mem_data;
    end
  end

  assign RegWrite      = reg_write_reg;
  assign rd            = rd_reg;
  assign rd_write_data = data_reg;

  // ---------------------------------------------------------------------------
  // Pending-load scoreboard
  // ---------------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_reg;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;
  logic        from_pop_reg;

  // Remembers whether the write currently on the port came from the FIFO,
  // since only load writebacks retire a pending-load entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      from_pop_reg <= 1'b0;
    end else begin
      from_pop_reg <= pop;
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    assign busy_set[gi] = ld_issue && (ld_issue_rd != 5'd0) && (ld_issue_rd == 5'(gi));
    assign busy_clr[gi] = reg_write_reg && from_pop_reg && (rd_reg == 5'(gi));
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg & ~busy_clr) | busy_set;
    end
  end

  assign rs1_busy = busy_reg[rs1];
  assign rs2_busy = busy_reg[rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{ld_issue, ld_issue_rd, rs1, rs2};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter (DEPTH = 2, STARVE_MAX = 4). Stimulus
// pushes each expected register-file write (rd, data, cycle) into a queue;
// a monitor on the falling edge pops and compares whenever RegWrite is high
// and flags writes that are missing, early, unexpected or wrong.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] rd_write_data;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .ld_issue      (ld_issue),
    .ld_issue_rd   (ld_issue_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .RegWrite      (RegWrite),
    .rd            (rd),
    .rd_write_data (rd_write_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.rd = r; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every write on the port against the expectation queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: no write seen, required x%0d=0x%0h at cycle %0d (now %0d)",
                 exp_q[0].rd, exp_q[0].data, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (RegWrite === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got x%0d=0x%0h at cycle %0d, required no write",
                   rd, rd_write_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rd !== e.rd || rd_write_data !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got x%0d=0x%0h at cycle %0d, required x%0d=0x%0h at cycle %0d",
                     rd, rd_write_data, cyc, e.rd, e.data, e.cyc);
          end else begin
            $display("ok   write x%0d=0x%0h at cycle %0d", rd, rd_write_data, cyc);
          end
        end
      end
    end
  end

  initial begin
    int k;
    logic force_cyc;
    logic exp_mr;

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    rs1 = '0; rs2 = '0;

    // ---------------- Reset values ----------------
    #3;
    chk("reset_RegWrite", 32'(RegWrite), 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_data", rd_write_data, 32'd0);
    chk("reset_mem_ready", 32'(mem_ready), 32'd1);
    chk("reset_alu_ready", 32'(alu_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    tick();

    // ---------------- ALU back-to-back, plus an x0 ALU write ----------------
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_1111;
    expect_write(5'd5, 32'h1111_1111, cyc + 1);
    tick();
    alu_rd = 5'd6; alu_data = 32'h2222_2222;
    expect_write(5'd6, 32'h2222_2222, cyc + 1);
    tick();
    alu_rd = 5'd0; alu_data = 32'h5555_5555;
    tick();
    alu_valid = 1'b0;
    repeat (2) tick();

    // ---------------- Load path with x0 filtering ----------------
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD_BEEF;
    #1 chk("load_mem_ready", 32'(mem_ready), 32'd1);
    expect_write(5'd7, 32'hDEAD_BEEF, cyc + 2);
    tick();
    mem_rd = 5'd0; mem_data = 32'h0000_0001;
    tick();
    mem_valid = 1'b0;
    repeat (3) tick();

    // ---------------- Fill and starve ----------------
    // Hand schedule: loads x8,x9 enter at steps 0,1; x10 waits until step 6.
    // Forced pops at steps 5 (x8), 10 (x9), 15 (x10).
    k = 0;
    for (int i = 0; i < 17; i++) begin
      force_cyc = (i == 5 || i == 10 || i == 15);
      exp_mr    = !((i >= 2 && i <= 5) || (i >= 7 && i <= 10));
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0000 + 32'(k);
      mem_valid = (i <= 6);
      mem_rd    = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10;
      mem_data  = 32'h8000_0000 | 32'(mem_rd);
      #1;
      chk($sformatf("starve_alu_ready[%0d]", i), 32'(alu_ready), 32'(!force_cyc));
      chk($sformatf("starve_mem_ready[%0d]", i), 32'(mem_ready), 32'(exp_mr));
      if (i == 5)       expect_write(5'd8,  32'h8000_0008, cyc + 1);
      else if (i == 10) expect_write(5'd9,  32'h8000_0009, cyc + 1);
      else if (i == 15) expect_write(5'd10, 32'h8000_000A, cyc + 1);
      else begin
        expect_write(5'd1, 32'hA000_0000 + 32'(k), cyc + 1);
        k++;
      end
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (3) tick();

    // ---------------- Scoreboard ----------------
    ld_issue = 1'b1; ld_issue_rd = 5'd12; rs1 = 5'd12; rs2 = 5'd13;
    tick();
    ld_issue = 1'b0;
    #1;
    chk("sb_rs1_busy_after_issue", 32'(rs1_busy), 32'(SB));
    chk("sb_rs2_busy_other_reg", 32'(rs2_busy), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hCAFE_F00D;
    expect_write(5'd12, 32'hCAFE_F00D, cyc + 2);
    tick();
    mem_valid = 1'b0;
    tick();                                   // writeback cycle
    #1 chk("sb_busy_during_write", 32'(rs1_busy), 32'(SB));
    tick();
    #1 chk("sb_busy_after_write", 32'(rs1_busy), 32'd0);
    // Re-issue x12 in the same cycle its older load writes back.
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    tick();
    ld_issue = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h1234_5678;
    expect_write(5'd12, 32'h1234_5678, cyc + 2);
    tick();
    mem_valid = 1'b0;
    tick();                                   // writeback cycle
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    tick();
    ld_issue = 1'b0;
    #1 chk("sb_reissue_set_wins", 32'(rs1_busy), 32'(SB));
    rs1 = 5'd0;
    #1 chk("sb_x0_never_busy", 32'(rs1_busy), 32'd0);
    tick();

    // ---------------- Reset mid-traffic ----------------
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0099;
    expect_write(5'd3, 32'h3333_3333, cyc + 1);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk); #1;                        // write x3 is on the port now
    rs1 = 5'd12;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_RegWrite", 32'(RegWrite), 32'd0);
    chk("midrst_rd", 32'(rd), 32'd0);
    chk("midrst_data", rd_write_data, 32'd0);
    chk("midrst_mem_ready", 32'(mem_ready), 32'd1);
    chk("midrst_rs1_busy", 32'(rs1_busy), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444_4444;
    #1 chk("midrst_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    #1 chk("midrst_no_effect", 32'(RegWrite), 32'd0);
    alu_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    // The pending x9 load was discarded: the monitor flags any write here.
    repeat (4) tick();
    chk("postrst_mem_ready", 32'(mem_ready), 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the integer pipeline. It merges two result producers, the single-cycle ALU path and the variable-latency load path, into the single register-file write port (`RegWrite`/`rd`/`rd_write_data`). A small FIFO buffers load results, and a bounded-starvation rule keeps the load path moving. An optional pending-load scoreboard lets decode detect load-use hazards.

## Interface
Parameters:
- `DEPTH`, 2: load-result FIFO entries; power of two, ≥2.
- `STARVE_MAX`, 4: consecutive cycles a non-empty FIFO may lose to the ALU before the FIFO is forced through; 1..15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_ready`  out  1  ALU result accepted this cycle; combinational.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `mem_valid`  in  1  load result present.
- `mem_ready`  out  1  equals FIFO not full; combinational from state.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  32  load result.
- `ld_issue`  in  1  a load is issued this cycle (scoreboard).
- `ld_issue_rd`  in  5  destination of the issued load.
- `rs1`, `rs2`  in  5 each  decode-stage source registers.
- `rs1_busy`, `rs2_busy`  out  1 each  source has a load outstanding; combinational.
- `RegWrite`  out  1  register-file write enable; registered.
- `rd`  out  5  register-file write address; registered.
- `rd_write_data`  out  32  register-file write data; registered.

## Operation
- **Transfers.** ALU transfer = `alu_valid && alu_ready`. Mem transfer = `mem_valid && mem_ready`.
- **rd = 0 filtering.**
  - A mem transfer with `mem_rd == 0` is accepted but not enqueued.
  - An ALU transfer with `alu_rd == 0` is accepted and produces no write (`RegWrite` = 0 next cycle).
- **Arbitration.** Evaluated each cycle, in priority order:
  1. Force: FIFO non-empty and `starve_cnt == STARVE_MAX`. Then `alu_ready` = 0, the FIFO head is popped and registered, and `starve_cnt` ← 0.
  2. Otherwise `alu_ready` = 1. If `alu_valid` is high, the ALU result is registered. If the FIFO is non-empty, `starve_cnt` increments.
  3. Otherwise, if the FIFO is non-empty, the head is popped and registered, and `starve_cnt` ← 0.
  4. Otherwise `RegWrite` ← 0.
- `starve_cnt` also clears whenever the FIFO is empty.
- **FIFO.** Circular buffer with read/write pointers plus one extra wrap bit. Full when the pointers are equal and the wrap bits differ. Empty when pointers and wrap bits are both equal. There is no bypass: an entry enqueued in cycle N is poppable from cycle N+1.
- **Width.** Data passes through unmodified at 32 bits; no sign handling is done here.

## Timing
- **Reset values.** `RegWrite` = 0, `rd` = 0, `rd_write_data` = 0, FIFO empty, `starve_cnt` = 0, all busy bits 0. While `rst_n` is low, `mem_ready` = 1 and `alu_ready` = 1, but no transfer has any effect.
- **Latency.**
  - ALU result to `RegWrite`: 1 cycle.
  - Load result to `RegWrite`: ≥2 cycles.
  - Each write holds `RegWrite` high for exactly one cycle.
- **Simultaneous pop and enqueue.** Both are allowed. The occupancy check uses start-of-cycle state, so a full FIFO refuses an enqueue even in a cycle where it pops.
- **Reset mid-operation.** Reset asserted at any point clears the FIFO and the output register immediately. Any in-flight results are lost; upstream must re-issue.
- **Upstream rule.** Producers hold valid/rd/data stable until their ready is seen high.

## Configuration
- Macro: `WB_SCOREBOARD_EN`.
- **Defined:**
  - A 32-bit busy vector is maintained.
  - `ld_issue` with `ld_issue_rd != 0` sets `busy[ld_issue_rd]`.
  - A cycle where `RegWrite` is high from a FIFO pop clears `busy[rd]`.
  - If a set and a clear target the same register in the same cycle, the set wins.
  - `rsN_busy = busy[rsN]`; register 0 always reads 0.
- **Undefined:** no busy storage exists, `rs1_busy` = `rs2_busy` = 0, and `ld_issue`/`ld_issue_rd` are ignored.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-traffic. Expect `RegWrite` = 0, `rd` = 0, `rd_write_data` = 0 immediately; then `mem_ready` = 1 and `rs1_busy` = 0.
- **ALU back-to-back:** ALU writes x5 = 0x11111111, then x6 = 0x22222222 on consecutive cycles. Expect `RegWrite` high for 2 cycles with exactly these address/data pairs, 1 cycle after each input.
- **Load path with x0 filtering:** mem x7 = 0xDEADBEEF, then mem x0 = 0x1 on the following cycle. Expect one write to x7 two cycles after acceptance, and no write for x0.
- **Fill and starve (DEPTH = 2, STARVE_MAX = 4):**
  - Continuous ALU traffic to x1. Push 3 loads (x8, x9, x10).
  - Expect `mem_ready` = 0 after 2 are enqueued.
  - After the FIFO has been non-empty for 4 ALU wins, `alu_ready` = 0 for one cycle and x8 is written.
  - The same pattern then repeats for the remaining loads.
- **Scoreboard (macro defined):** `ld_issue` for x12; `rs1` = 12 reads busy = 1. Load x12 writes back; busy = 0 in the cycle after `RegWrite`. A same-cycle re-issue of x12 keeps busy = 1.
- **Scoreboard compiled out (macro undefined):** `ld_issue` for x12 with `rs1` = 12 leaves `rs1_busy` = 0.
